// File: rtl/ipmxb_qsgmii_hsst_lane_powerdown_v1_0.sv
// HSST lane power-down / restart sequencer.
// Takes ownership of the lane PD/RST pins on a user request or on PLL loss.
// It asserts reset first, then power-down, and acknowledges once the lane is off.
// On release it hands the lane back to the power-up block by restarting that block.
module ipmxb_qsgmii_hsst_lane_powerdown_v1_0 #(
    parameter int    FREE_CLOCK_FREQ = 100,
    parameter string PLL_LOSS_EN     = "TRUE",
    parameter int    RELEASE_CYCLES  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pd_req,
    input  logic i_pll_done,
    output logic o_override,
    output logic o_lane_pd,
    output logic o_lane_rst,
    output logic o_pu_restart,
    output logic o_pd_ack,
    output logic o_pll_lost,
    output logic o_busy
);

    localparam int RstHold = 2 * (1 * FREE_CLOCK_FREQ);
`ifdef IPML_HSST_SPEEDUP_SIM
    localparam int PdSettle = 2 * (1 * FREE_CLOCK_FREQ);
`else
    localparam int PdSettle = 2 * (40 * FREE_CLOCK_FREQ);
`endif

    localparam logic [13:0] RstHoldLast  = 14'(RstHold - 1);
    localparam logic [13:0] PdSettleLast = 14'(PdSettle - 1);
    localparam logic [13:0] ReleaseLast  = 14'(RELEASE_CYCLES - 1);
    localparam logic        LossEn       = (PLL_LOSS_EN == "TRUE");

    localparam logic [2:0] StActive  = 3'd0;
    localparam logic [2:0] StRstOn   = 3'd1;
    localparam logic [2:0] StPdOn    = 3'd2;
    localparam logic [2:0] StDown    = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [13:0] cnt_q, cnt_d;
    logic        pll_lost_d;
    logic        pll_meta_q, pll_sync_q, pll_prev_q;
    logic        pll_lost_evt;

    // Two-flop synchroniser for the asynchronous PLL-done flag, plus one delay for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_meta_q <= 1'b0;
            pll_sync_q <= 1'b0;
            pll_prev_q <= 1'b0;
        end else begin
            pll_meta_q <= i_pll_done;
            pll_sync_q <= pll_meta_q;
            pll_prev_q <= pll_sync_q;
        end
    end

    assign pll_lost_evt = LossEn && pll_prev_q && !pll_sync_q;

    // Next-state, dwell counter and loss-flag logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pll_lost_d = o_pll_lost;
        case (state_q)
            StActive: begin
                if (i_pd_req || pll_lost_evt) begin
                    state_d    = StRstOn;
                    cnt_d      = '0;
                    pll_lost_d = pll_lost_evt;
                end
            end
            StRstOn: begin
                if (cnt_q == RstHoldLast) begin
                    state_d = StPdOn;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            StPdOn: begin
                if (cnt_q == PdSettleLast) begin
                    state_d = StDown;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            StDown: begin
                // A loss-triggered sequence holds the lane down until the PLL locks again.
                if (!(i_pd_req || (o_pll_lost && !pll_sync_q))) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end
            StRelease: begin
                if (cnt_q == ReleaseLast) begin
                    state_d    = StActive;
                    cnt_d      = '0;
                    pll_lost_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            default: begin
                state_d    = StActive;
                cnt_d      = '0;
                pll_lost_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StActive;
            cnt_q        <= '0;
            o_override   <= 1'b0;
            o_lane_rst   <= 1'b0;
            o_lane_pd    <= 1'b0;
            o_pu_restart <= 1'b0;
            o_pd_ack     <= 1'b0;
            o_pll_lost   <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            o_override   <= (state_d != StActive);
            o_lane_rst   <= (state_d != StActive);
            // Release keeps pd/rst high so the pin mux switches to the restarted
            // power-up block, which also drives pd=1/rst=1, without a glitch.
            o_lane_pd    <= (state_d == StPdOn) || (state_d == StDown) || (state_d == StRelease);
            o_pu_restart <= (state_d != StActive);
            o_pd_ack     <= (state_d == StDown);
            o_pll_lost   <= pll_lost_d;
            o_busy       <= (state_d != StActive);
        end
    end

endmodule

// File: tb/tb_ipmxb_qsgmii_hsst_lane_powerdown_v1_0.sv
// Bench for the lane power-down sequencer: timestamp-based reference model plus directed
// and random scenarios.
module tb_ipmxb_qsgmii_hsst_lane_powerdown_v1_0;

    localparam int RstHold  = 20;
    localparam int PdSettle = 800;
    localparam int RelCyc   = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic req, req_off, pll_done;
    logic ovr, pd, lrst, rs, ack, lost, busy;
    logic ovr_b, pd_b, lrst_b, rs_b, ack_b, lost_b, busy_b;
    logic [6:0] obs, obs_off;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ipmxb_qsgmii_hsst_lane_powerdown_v1_0 #(
        .FREE_CLOCK_FREQ(10), .PLL_LOSS_EN("TRUE"), .RELEASE_CYCLES(RelCyc)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_pd_req(req), .i_pll_done(pll_done),
        .o_override(ovr), .o_lane_pd(pd), .o_lane_rst(lrst), .o_pu_restart(rs),
        .o_pd_ack(ack), .o_pll_lost(lost), .o_busy(busy)
    );

    ipmxb_qsgmii_hsst_lane_powerdown_v1_0 #(
        .FREE_CLOCK_FREQ(10), .PLL_LOSS_EN("FALSE"), .RELEASE_CYCLES(RelCyc)
    ) dut_off (
        .clk(clk), .rst_n(rst_n), .i_pd_req(req_off), .i_pll_done(pll_done),
        .o_override(ovr_b), .o_lane_pd(pd_b), .o_lane_rst(lrst_b), .o_pu_restart(rs_b),
        .o_pd_ack(ack_b), .o_pll_lost(lost_b), .o_busy(busy_b)
    );

    assign obs     = {ovr, lrst, pd, rs, ack, lost, busy};
    assign obs_off = {ovr_b, lrst_b, pd_b, rs_b, ack_b, lost_b, busy_b};

    // Reference model: phase 0 idle, 1 resetting, 2 powering down, 3 down, 4 releasing.
    // Timed phases end at an absolute edge number rather than via a counter.
    int m_phase, m_cyc, m_dl;
    bit m_lost, m_h0, m_h1, m_h2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cyc   <= 0;
            m_dl    <= 0;
            m_lost  <= 1'b0;
            m_h0    <= 1'b0;
            m_h1    <= 1'b0;
            m_h2    <= 1'b0;
        end else begin : model_step
            int now, ph, dl;
            bit lst, evt, synced;
            now    = m_cyc + 1;
            ph     = m_phase;
            dl     = m_dl;
            lst    = m_lost;
            synced = m_h1;                  // pll_done as seen two edges ago
            evt    = m_h2 && !m_h1;
            case (ph)
                0: if (req || evt) begin ph = 1; dl = now + RstHold; lst = evt; end
                1: if (now == dl) begin ph = 2; dl = now + PdSettle; end
                2: if (now == dl) ph = 3;
                3: if (!(req || (lst && !synced))) begin ph = 4; dl = now + RelCyc; end
                4: if (now == dl) begin ph = 0; lst = 1'b0; end
                default: ph = 0;
            endcase
            m_phase <= ph;
            m_dl    <= dl;
            m_lost  <= lst;
            m_cyc   <= now;
            m_h2    <= m_h1;
            m_h1    <= m_h0;
            m_h0    <= pll_done;
        end
    end

    function automatic logic [6:0] exp_vec();
        logic on;
        on = (m_phase != 0);
        return {on, on, (m_phase >= 2), on, (m_phase == 3), m_lost, on};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; req_off = 1'b0; pll_done = 1'b1;
        #3;
        n_checks++;
        if (obs !== 7'b0) $display("FAIL reset_main: got %b want %b", obs, 7'b0);
        else n_pass++;
        n_checks++;
        if (obs_off !== 7'b0) $display("FAIL reset_off: got %b want %b", obs_off, 7'b0);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (obs !== 7'b0) $display("FAIL idle_after_reset: got %b want %b", obs, 7'b0);
        else n_pass++;
    endtask

    task automatic test_req_sequence();
        req = 1'b1;
        @(negedge clk);                         // after E0
        n_checks++;
        if (obs !== 7'b1101001) $display("FAIL rst_on_entry: got %b want %b", obs, 7'b1101001);
        else n_pass++;
        for (int i = 1; i <= 820; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL seq_cycle%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
            if (i == 19 || i == 20) begin
                n_checks++;
                if (pd !== (i == 20)) $display("FAIL pd_at_E%0d: got %b want %b", i, pd, i == 20);
                else n_pass++;
            end
            if (i == 819 || i == 820) begin
                n_checks++;
                if (ack !== (i == 820)) $display("FAIL ack_at_E%0d: got %b want %b", i, ack, i == 820);
                else n_pass++;
            end
        end
        n_checks++;
        if (lost !== 1'b0) $display("FAIL req_pll_lost: got %b want 0", lost);
        else n_pass++;
        repeat (3) @(negedge clk);
        req = 1'b0;
        @(negedge clk);                         // after E
        n_checks++;
        if ({ack, ovr} !== 2'b01) $display("FAIL release_entry: got %b want 01", {ack, ovr});
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ovr !== 1'b1) $display("FAIL release_E3_override: got %b want 1", ovr);
        else n_pass++;
        @(negedge clk);                         // after E+4
        n_checks++;
        if ({ovr, rs, busy} !== 3'b000) $display("FAIL handback: got %b want 000", {ovr, rs, busy});
        else n_pass++;
    endtask

    task automatic test_pulse();
        req = 1'b1;
        @(negedge clk);                         // after E0
        req = 1'b0;
        for (int i = 1; i <= 820; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL pulse_cycle%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (ack !== 1'b1) $display("FAIL pulse_ack_E820: got %b want 1", ack);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({ack, busy} !== 2'b01) $display("FAIL pulse_E821: got %b want 01", {ack, busy});
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL pulse_E824_busy: got %b want 1", busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs !== 7'b0) $display("FAIL pulse_E825_idle: got %b want %b", obs, 7'b0);
        else n_pass++;
    endtask

    task automatic test_pll_loss();
        pll_done = 1'b0;
        repeat (2) @(negedge clk);              // after E2
        n_checks++;
        if (ovr !== 1'b0) $display("FAIL loss_E2_idle: got %b want 0", ovr);
        else n_pass++;
        @(negedge clk);                         // after E3
        n_checks++;
        if ({ovr, lost} !== 2'b11) $display("FAIL loss_start: got %b want 11", {ovr, lost});
        else n_pass++;
        for (int i = 0; i < 850; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL loss_cycle%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({ack, lost} !== 2'b11) $display("FAIL loss_held_down: got %b want 11", {ack, lost});
        else n_pass++;
        pll_done = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ack !== 1'b1) $display("FAIL loss_sync_delay: got %b want 1", ack);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({ack, busy, lost} !== 3'b011) $display("FAIL loss_release: got %b want 011", {ack, busy, lost});
        else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++;
        if (obs !== 7'b0) $display("FAIL loss_handback: got %b want %b", obs, 7'b0);
        else n_pass++;
    endtask

    task automatic test_pll_loss_disabled();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_off !== 7'b0) $display("FAIL off_cycle%0d: got %b want %b", i, obs_off, 7'b0);
            else n_pass++;
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL off_main%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
            if ($urandom_range(0, 9) == 0) pll_done = ~pll_done;
        end
        pll_done = 1'b1;
        begin
            bit done;
            done = 1'b0;
            for (int i = 0; i < 2000 && !done; i++) begin
                @(negedge clk);
                if (!busy && m_phase == 0) done = 1'b1;
            end
            n_checks++;
            if (!done) $display("FAIL off_settle_timeout: got busy=%b want 0", busy);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        req = 1'b1;
        repeat (100) @(negedge clk);            // inside the power-down settle
        n_checks++;
        if (pd !== 1'b1) $display("FAIL mid_in_pd_on: got %b want 1", pd);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 7'b0) $display("FAIL async_reset: got %b want %b", obs, 7'b0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);                         // first edge out of reset samples req=1
        for (int i = 1; i <= 820; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL rerun_cycle%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
            if (i == 20) begin
                n_checks++;
                if (pd !== 1'b1) $display("FAIL rerun_pd_E20: got %b want 1", pd);
                else n_pass++;
            end
        end
        n_checks++;
        if (ack !== 1'b1) $display("FAIL rerun_ack_E820: got %b want 1", ack);
        else n_pass++;
        req = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL rand_cycle%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
            if ($urandom_range(0, 299) == 0) req = ~req;
            if ($urandom_range(0, 399) == 0) pll_done = ~pll_done;
        end
    endtask

    initial begin
        test_reset();
        test_req_sequence();
        test_pulse();
        test_pll_loss();
        test_pll_loss_disabled();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
